// File: rtl/game_pkg.sv
// Shared types for the penalty shoot-out game: screen states, play modes and
// the match-decision verdict, plus the counter-width helper.
package game_pkg;

    typedef enum logic [2:0] {
        START,
        KEEPER,
        SHOOTER,
        WINNER,
        LOOSER,
        DRAW
    } g_state;

    typedef enum logic {
        SOLO,
        MULTI
    } g_mode;

    typedef enum logic [1:0] {
        DEC_NONE,
        DEC_WIN,
        DEC_LOSE,
        DEC_DRAW
    } decision_t;

    // Counters must hold ROUNDS+SD_MAX without wrapping.
    function automatic int cnt_width(input int rounds, input int sd_max);
        return $clog2(rounds + sd_max + 1);
    endfunction

endpackage

// File: rtl/penalty_match_ctl_if.sv
// Bundle between the mouse/shot logic, the match controller and the display path.
interface penalty_match_ctl_if #(
    parameter int ROUNDS = 5,
    parameter int SD_MAX = 3
);
    import game_pkg::*;

    localparam int CW = cnt_width(ROUNDS, SD_MAX);

    logic          left_clicked;
    logic          right_clicked;
    logic          solo_enable;
    logic          link_up;
    logic          is_host;
    logic          round_done;
    logic          is_scored;
    g_state        game_state;
    g_mode         game_mode;
    logic [CW-1:0] round_counter;
    logic [CW-1:0] player_score;
    logic [CW-1:0] opp_score;
    logic          sudden_death;

    modport master (
        output left_clicked, right_clicked, solo_enable, link_up, is_host,
               round_done, is_scored,
        input  game_state, game_mode, round_counter, player_score, opp_score,
               sudden_death
    );

    modport slave (
        input  left_clicked, right_clicked, solo_enable, link_up, is_host,
               round_done, is_scored,
        output game_state, game_mode, round_counter, player_score, opp_score,
               sudden_death
    );

endinterface

// File: rtl/match_decider.sv
// Pure-combinational verdict on post-shot scores/shot counts: early
// mathematical decision in regulation, pair-by-pair decision in sudden death.
module match_decider
    import game_pkg::*;
#(
    parameter int ROUNDS = 5,
    parameter int SD_MAX = 3,
    parameter int CW     = cnt_width(ROUNDS, SD_MAX)
) (
    input  logic [CW-1:0] ply_score,
    input  logic [CW-1:0] opp_score,
    input  logic [CW-1:0] ply_shots,
    input  logic [CW-1:0] opp_shots,
    input  logic [CW-1:0] round_cnt,
    output decision_t     decision
);
    localparam int            W          = CW + 1;
    localparam logic [CW-1:0] ROUNDS_C   = CW'(ROUNDS);
    localparam logic [CW-1:0] LAST_RND_C = CW'(ROUNDS + SD_MAX);

    logic         in_sd;
    logic         pair_done;
    logic [W-1:0] ps_ext;
    logic [W-1:0] os_ext;
    logic [W-1:0] rem_p;
    logic [W-1:0] rem_o;

    always_comb begin
        decision  = DEC_NONE;
        in_sd     = round_cnt > ROUNDS_C;
        pair_done = ply_shots == opp_shots;
        ps_ext    = {1'b0, ply_score};
        os_ext    = {1'b0, opp_score};
        rem_p     = {1'b0, ROUNDS_C - ply_shots};
        rem_o     = {1'b0, ROUNDS_C - opp_shots};

        // Remaining-shot lookahead only makes sense within regulation.
        if (!in_sd) begin
            if (ps_ext > os_ext + rem_o) begin
                decision = DEC_WIN;
            end else if (os_ext > ps_ext + rem_p) begin
                decision = DEC_LOSE;
            end
        end

        if (decision == DEC_NONE && pair_done) begin
            if (in_sd && ply_score != opp_score) begin
                decision = (ply_score > opp_score) ? DEC_WIN : DEC_LOSE;
            end else if (ply_score == opp_score && round_cnt == LAST_RND_C) begin
                decision = DEC_DRAW;
            end
        end
    end

endmodule

// File: rtl/penalty_match_ctl.sv
// Penalty shoot-out match controller: role alternation, per-side counters,
// early decision, sudden death and link-gated multiplayer.
module penalty_match_ctl
    import game_pkg::*;
#(
    parameter  int ROUNDS = 5,
    parameter  int SD_MAX = 3,
    localparam int CW     = cnt_width(ROUNDS, SD_MAX)
) (
    input  logic              clk,
    input  logic              rst_n,
    penalty_match_ctl_if.slave bus
);
    localparam logic [CW-1:0] ROUNDS_C = CW'(ROUNDS);

    g_state        state_q,        state_d;
    g_mode         mode_q,         mode_d;
    logic          first_keeper_q, first_keeper_d;
    logic [CW-1:0] round_q,        round_d;
    logic [CW-1:0] ply_score_q,    ply_score_d;
    logic [CW-1:0] opp_score_q,    opp_score_d;
    logic [CW-1:0] ply_shots_q,    ply_shots_d;
    logic [CW-1:0] opp_shots_q,    opp_shots_d;
    logic          sd_q,           sd_d;

    logic [CW-1:0] ply_score_upd;
    logic [CW-1:0] opp_score_upd;
    logic [CW-1:0] ply_shots_upd;
    logic [CW-1:0] opp_shots_upd;
    logic [CW-1:0] round_inc;
    logic          pair_done;
    logic          clear_ctrs;
    decision_t     decision;

    // Counters as they would stand if the current shot is accepted.
    always_comb begin : shot_update
        ply_score_upd = ply_score_q;
        opp_score_upd = opp_score_q;
        ply_shots_upd = ply_shots_q;
        opp_shots_upd = opp_shots_q;
        if (state_q == SHOOTER) begin
            ply_shots_upd = ply_shots_q + CW'(1);
            if (bus.is_scored) ply_score_upd = ply_score_q + CW'(1);
        end else if (state_q == KEEPER) begin
            opp_shots_upd = opp_shots_q + CW'(1);
            if (bus.is_scored) opp_score_upd = opp_score_q + CW'(1);
        end
    end

    match_decider #(
        .ROUNDS (ROUNDS),
        .SD_MAX (SD_MAX),
        .CW     (CW)
    ) u_decider (
        .ply_score (ply_score_upd),
        .opp_score (opp_score_upd),
        .ply_shots (ply_shots_upd),
        .opp_shots (opp_shots_upd),
        .round_cnt (round_q),
        .decision  (decision)
    );

    always_ff @(posedge clk) begin : state_reg
        if (!rst_n) begin
            state_q        <= START;
            mode_q         <= MULTI;
            first_keeper_q <= 1'b0;
            round_q        <= '0;
            ply_score_q    <= '0;
            opp_score_q    <= '0;
            ply_shots_q    <= '0;
            opp_shots_q    <= '0;
            sd_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            first_keeper_q <= first_keeper_d;
            round_q        <= round_d;
            ply_score_q    <= ply_score_d;
            opp_score_q    <= opp_score_d;
            ply_shots_q    <= ply_shots_d;
            opp_shots_q    <= opp_shots_d;
            sd_q           <= sd_d;
        end
    end

    always_comb begin : next_state
        state_d        = state_q;
        mode_d         = mode_q;
        first_keeper_d = first_keeper_q;
        round_d        = round_q;
        ply_score_d    = ply_score_q;
        opp_score_d    = opp_score_q;
        ply_shots_d    = ply_shots_q;
        opp_shots_d    = opp_shots_q;
        sd_d           = sd_q;
        clear_ctrs     = 1'b0;
        round_inc      = round_q + CW'(1);
        // The second shot of a pair is taken in the role opposite the opening one.
        pair_done      = (state_q == KEEPER) != first_keeper_q;

        case (state_q)
            START: begin
                mode_d     = bus.solo_enable ? SOLO : MULTI;
                clear_ctrs = 1'b1;
                if (bus.left_clicked && (bus.solo_enable || bus.link_up)) begin
                    first_keeper_d = bus.solo_enable || bus.is_host;
                    state_d        = first_keeper_d ? KEEPER : SHOOTER;
                end
            end
            KEEPER, SHOOTER: begin
                // Link loss outranks a shot arriving in the same cycle.
                if (mode_q == MULTI && !bus.link_up) begin
                    state_d    = START;
                    clear_ctrs = 1'b1;
                end else if (bus.round_done) begin
                    ply_score_d = ply_score_upd;
                    opp_score_d = opp_score_upd;
                    ply_shots_d = ply_shots_upd;
                    opp_shots_d = opp_shots_upd;
                    case (decision)
                        DEC_WIN:  state_d = WINNER;
                        DEC_LOSE: state_d = LOOSER;
                        DEC_DRAW: state_d = DRAW;
                        default: begin
                            state_d = (state_q == KEEPER) ? SHOOTER : KEEPER;
                            if (pair_done) begin
                                round_d = round_inc;
                                sd_d    = sd_q | (round_inc > ROUNDS_C);
                            end
                        end
                    endcase
                end
            end
            WINNER, LOOSER, DRAW: begin
                if (bus.right_clicked) begin
                    state_d    = START;
                    clear_ctrs = 1'b1;
                end
            end
            default: state_d = START;
        endcase

        if (clear_ctrs) begin
            ply_score_d = '0;
            opp_score_d = '0;
            ply_shots_d = '0;
            opp_shots_d = '0;
            sd_d        = 1'b0;
            round_d     = (state_d == START) ? '0 : CW'(1);
        end
    end

    always_comb begin : outputs
        bus.game_state    = state_q;
        bus.game_mode     = mode_q;
        bus.round_counter = round_q;
        bus.player_score  = ply_score_q;
        bus.opp_score     = opp_score_q;
        bus.sudden_death  = sd_q;
    end

endmodule

// File: tb/tb_penalty_match_ctl.sv
// Scoreboard bench for penalty_match_ctl: directed match scenarios plus random
// matches, checked against a shot-by-shot behavioural model of the rules.
module tb_penalty_match_ctl;
    import game_pkg::*;

    localparam int R  = 5;
    localparam int SD = 3;
    localparam int CW = cnt_width(R, SD);

    typedef struct packed {
        g_state        st;
        g_mode         md;
        logic [CW-1:0] rnd;
        logic [CW-1:0] ps;
        logic [CW-1:0] os;
        logic          sd;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    penalty_match_ctl_if #(.ROUNDS(R), .SD_MAX(SD)) bus ();

    penalty_match_ctl #(.ROUNDS(R), .SD_MAX(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    snap_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model: a match is a list of shots per side plus a verdict.
    g_state m_state;
    g_mode  m_mode;
    int     m_ps, m_os, m_psh, m_osh, m_round;
    bit     m_sd;

    function automatic int decide(int ps, int os, int psh, int osh, int rnd);
        bit in_sd = rnd > R;
        if (!in_sd) begin
            if (ps > os + (R - osh)) return 1;
            if (os > ps + (R - psh)) return 2;
        end
        if (psh == osh) begin
            if (in_sd && ps > os) return 1;
            if (in_sd && os > ps) return 2;
            if (ps == os && (in_sd ? (rnd == R + SD) : (SD == 0 && psh == R))) return 3;
        end
        return 0;
    endfunction

    task automatic model_clear();
        m_ps = 0; m_os = 0; m_psh = 0; m_osh = 0; m_round = 0; m_sd = 0;
    endtask

    task automatic model_edge(input bit lc, input bit rc, input bit rd, input bit sc);
        int d;
        if (!rst_n) begin
            m_state = START; m_mode = MULTI; model_clear();
            return;
        end
        case (m_state)
            START: begin
                m_mode = bus.solo_enable ? SOLO : MULTI;
                model_clear();
                if (lc && (bus.solo_enable || bus.link_up)) begin
                    m_state = (bus.solo_enable || bus.is_host) ? KEEPER : SHOOTER;
                    m_round = 1;
                end
            end
            KEEPER, SHOOTER: begin
                if (m_mode == MULTI && !bus.link_up) begin
                    m_state = START; model_clear();
                end else if (rd) begin
                    if (m_state == KEEPER) begin m_osh++; m_os += int'(sc); end
                    else                   begin m_psh++; m_ps += int'(sc); end
                    d = decide(m_ps, m_os, m_psh, m_osh, m_round);
                    if (d == 1)      m_state = WINNER;
                    else if (d == 2) m_state = LOOSER;
                    else if (d == 3) m_state = DRAW;
                    else begin
                        m_state = (m_state == KEEPER) ? SHOOTER : KEEPER;
                        if (m_psh == m_osh) begin
                            m_round = m_psh + 1;
                            m_sd    = m_round > R;
                        end
                    end
                end
            end
            default: if (rc) begin m_state = START; model_clear(); end
        endcase
    endtask

    // One clock of stimulus; the model's post-edge expectation goes to the scoreboard.
    task automatic cyc(input bit lc, input bit rc, input bit rd, input bit sc);
        snap_t e;
        bus.left_clicked  = lc;
        bus.right_clicked = rc;
        bus.round_done    = rd;
        bus.is_scored     = sc;
        @(posedge clk);
        #1;
        model_edge(lc, rc, rd, sc);
        e.st = m_state; e.md = m_mode; e.rnd = CW'(m_round);
        e.ps = CW'(m_ps); e.os = CW'(m_os); e.sd = m_sd;
        sb.push_back(e);
        bus.left_clicked = 1'b0; bus.right_clicked = 1'b0;
        bus.round_done   = 1'b0; bus.is_scored     = 1'b0;
        @(negedge clk);
    endtask

    // Shot i is scored when bit i of pat is set.
    task automatic shots(input logic [31:0] pat, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, pat[i]);
    endtask

    task automatic start_solo();
        bus.solo_enable = 1'b1; bus.link_up = 1'b1; bus.is_host = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic back_to_start();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        snap_t e, got;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got.st = bus.game_state;    got.md = bus.game_mode;
                got.rnd = bus.round_counter; got.ps = bus.player_score;
                got.os = bus.opp_score;     got.sd = bus.sudden_death;
                n_vec++;
                $display("t=%0t st=%0d md=%0d rnd=%0d ps=%0d os=%0d sd=%0d", $time,
                         got.st, got.md, got.rnd, got.ps, got.os, got.sd);
                if (got !== e) begin
                    n_err++;
                    $display("FAIL snapshot: got st=%0d md=%0d rnd=%0d ps=%0d os=%0d sd=%0d, expected st=%0d md=%0d rnd=%0d ps=%0d os=%0d sd=%0d",
                             got.st, got.md, got.rnd, got.ps, got.os, got.sd,
                             e.st, e.md, e.rnd, e.ps, e.os, e.sd);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        bus.left_clicked = 1'b0; bus.right_clicked = 1'b0;
        bus.round_done   = 1'b0; bus.is_scored     = 1'b0;
        bus.solo_enable  = 1'b0; bus.link_up       = 1'b0; bus.is_host = 1'b0;
        m_state = START; m_mode = MULTI; model_clear();
        @(negedge clk);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Keeper miss / shooter goal x3 -> WINNER 3-0 in round 3.
        start_solo();
        shots(32'b101010, 6);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        back_to_start();

        // Opponent scores 3, player misses 3 -> LOOSER.
        start_solo();
        shots(32'b010101, 6);
        back_to_start();

        // 5 goal pairs -> sudden death round 6; opp goal then player miss -> LOOSER 5-6.
        start_solo();
        shots(32'h3FF, 10);
        shots(32'b01, 2);
        back_to_start();

        // All goals through sudden death -> DRAW at round 8, 8-8.
        start_solo();
        shots(32'hFFFF, 16);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        back_to_start();

        // Multiplayer guest: link drop mid-match, then click without link.
        bus.solo_enable = 1'b0; bus.is_host = 1'b0; bus.link_up = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        shots(32'b11, 2);
        bus.link_up = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        bus.link_up = 1'b1; bus.is_host = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        shots(32'b1, 1);

        // Mode frozen mid-match, link ignored in solo, reset mid-match, shot in START.
        rst_n = 1'b0; cyc(1'b0, 1'b0, 1'b0, 1'b0); rst_n = 1'b1;
        start_solo();
        bus.solo_enable = 1'b0; bus.link_up = 1'b0;
        shots(32'b0110, 4);
        rst_n = 1'b0; cyc(1'b0, 1'b0, 1'b1, 1'b1); rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);

        // Random matches with noise clicks, link drops, mode toggles and resets.
        for (int m = 0; m < 40; m++) begin
            bus.solo_enable = 1'($urandom_range(0, 1));
            bus.is_host     = 1'($urandom_range(0, 1));
            bus.link_up     = 1'b1;
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 40; c++) begin
                int r;
                bit is_end;
                r = $urandom_range(0, 199);
                is_end = (m_state == WINNER || m_state == LOOSER || m_state == DRAW);
                if (r < 3)  bus.link_up = 1'b0;
                if (r == 3) bus.solo_enable = ~bus.solo_enable;
                if (r == 4) rst_n = 1'b0;
                cyc($urandom_range(0, 9) == 0,
                    is_end ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0),
                    $urandom_range(0, 2) != 0,
                    1'($urandom_range(0, 1)));
                rst_n = 1'b1;
                bus.link_up = 1'b1;
            end
            back_to_start();
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/penalty_match_ctl.md
# penalty_match_ctl

Parametrised match controller for the penalty shoot-out game: the successor to the fixed solo-only state selector. Tracks per-side shots and goals over a configurable number of regulation rounds, alternates the local player between KEEPER and SHOOTER, ends the match early once the result is mathematically decided, and runs optional sudden death. Supports solo play and link-gated multiplayer with host/guest starting roles. Sits between the mouse/shot logic (clicks, `round_done`) and the display/score path (state, mode, counters).

## Interface
Parameters:
- `ROUNDS`, 5: regulation shots per side (≥1).
- `SD_MAX`, 3: maximum sudden-death pairs; 0 disables sudden death.
- `CW`, `$clog2(ROUNDS+SD_MAX+1)`: counter width (derived, not overridden).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `left_clicked` in 1: one-cycle pulse; starts a match.
- `right_clicked` in 1: one-cycle pulse; returns from an end screen.
- `solo_enable` in 1: level; selects SOLO (1) or MULTI (0), sampled only in START.
- `link_up` in 1: level; multiplayer link established.
- `is_host` in 1: level; this board is host. Sampled in START.
- `round_done` in 1: one-cycle pulse; the current shot is finished.
- `is_scored` in 1: valid with `round_done`; 1 = goal.
- `game_state` out `g_state`: START/KEEPER/SHOOTER/WINNER/LOOSER/DRAW.
- `game_mode` out `g_mode`: SOLO/MULTI.
- `round_counter` out CW: current round, 1-based; 0 in START.
- `player_score` out CW: goals scored by the local player.
- `opp_score` out CW: goals conceded by the local player.
- `sudden_death` out 1: high while the match is in sudden-death rounds.

## Operation
- Mode: in START, `game_mode` ← SOLO if `solo_enable`, else MULTI. Frozen in every other state.
- START → first role on `left_clicked`, gated by `link_up` in MULTI. SOLO and MULTI host start in KEEPER; MULTI guest starts in SHOOTER. Role is latched as `first_keeper`. `round_counter` ← 1. Scores, shot counts and `sudden_death` are cleared.
- KEEPER: on `round_done`, `opp_shots`++, and `opp_score`++ if `is_scored`.
- SHOOTER: on `round_done`, `ply_shots`++, and `player_score`++ if `is_scored`.
- After each shot, evaluate the decision on the post-update values. Let `rem_p = ROUNDS − ply_shots` and `rem_o = ROUNDS − opp_shots` while in regulation; both are 0 in sudden death.
  - `player_score > opp_score + rem_o` → WINNER.
  - `opp_score > player_score + rem_p` → LOOSER.
  - Otherwise, in sudden death, once a pair completes (`ply_shots == opp_shots`):
    - scores differ → WINNER or LOOSER;
    - scores equal and `round_counter == ROUNDS+SD_MAX` → DRAW.
  - With `SD_MAX = 0`, a tie after ROUNDS pairs → DRAW.
  - Otherwise switch to the other role (KEEPER↔SHOOTER).
- On pair completion with no decision: `round_counter`++. Set `sudden_death` when the new round exceeds ROUNDS.
- WINNER/LOOSER/DRAW → START on `right_clicked`. Scores are held for display until then.
- MULTI, `link_up` low in KEEPER/SHOOTER → START, all counters cleared. End screens are unaffected by `link_up`.
- Ignore `round_done` in START and on end screens. Ignore `left_clicked` outside START and `right_clicked` outside end screens.

## Timing
- All outputs are registered and update on the clock edge that samples the causing event. The score increment, role switch or decision appear together one cycle after `round_done`.
- Reset (`rst_n` = 0 at an edge), including mid-match:
  - `game_state` = START, `game_mode` = MULTI;
  - `round_counter`, `player_score`, `opp_score` = 0;
  - `sudden_death` = 0.
- `round_done` is one pulse per shot. Back-to-back pulses in consecutive cycles are each accepted, against the role current at that edge.
- If `link_up` falls in the same cycle as `round_done`, link loss wins: go to START and discard the shot.
- Counters never exceed `ROUNDS+SD_MAX`, so no wrap is possible.

## Structure
- Add DRAW to `g_state` in `game_pkg`; `g_mode` is unchanged.
- The pure-combinational decision function (scores, shots, round, parameters → {NONE, WIN, LOSE, DRAW}) lives in the sub-module `match_decider`. The FSM and counters live in `penalty_match_ctl`.

## Test plan
- SOLO, ROUNDS=5: keeper-miss and shooter-goal alternate three times → WINNER on the edge after the 6th `round_done`, with `player_score` = 3, `opp_score` = 0, `round_counter` = 3.
- SOLO: opponent scores 3 and player misses 3 → LOOSER after the 6th shot, with `opp_score` = 3.
- SOLO, every shot a goal for 5 pairs → `sudden_death` = 1 and `round_counter` = 6. Round 6 opponent goal then player miss → LOOSER, score 5–6.
- SOLO, SD_MAX=3, all goals → DRAW after the 16th `round_done`, with `round_counter` = 8 and scores 8–8.
- MULTI guest (`is_host` = 0, `link_up` = 1): `left_clicked` → SHOOTER. After two shots drop `link_up` → START next cycle, all counters 0. `left_clicked` with `link_up` = 0 stays in START.
- Mid-match: toggling `solo_enable` leaves `game_mode` unchanged. `rst_n` low for one edge → all reset values. `round_done` in START leaves the scores at 0.
